// File: rtl/bcd_7segment_ca.sv
// Registered BCD-to-seven-segment decoder for a common-anode display. Segment outputs are active-low.
// Optional build macro HEX_DIGITS_EN: codes 10-15 show hex glyphs A..F instead of blanking and flagging invalid.
module bcd_7segment_ca (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] B,
  input  logic       lamp_test,
  input  logic       blank,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       invalid
);

  // Segment vectors are ordered {a,b,c,d,e,f,g}; 0 lights a segment.
  localparam logic [6:0] SEG_DARK = 7'b111_1111;
  localparam logic [6:0] SEG_LIT  = 7'b000_0000;

  logic [6:0] seg_d, seg_q;
  logic       invalid_d, invalid_q;
  logic [6:0] glyph;
  logic       glyph_invalid;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    glyph         = SEG_DARK;
    glyph_invalid = 1'b0;
    unique case (B)
      4'd0:    glyph = 7'b000_0001;
      4'd1:    glyph = 7'b100_1111;
      4'd2:    glyph = 7'b001_0010;
      4'd3:    glyph = 7'b000_0110;
      4'd4:    glyph = 7'b100_1100;
      4'd5:    glyph = 7'b010_0100;
      4'd6:    glyph = 7'b010_0000;
      4'd7:    glyph = 7'b000_1111;
      4'd8:    glyph = 7'b000_0000;
      4'd9:    glyph = 7'b000_0100;
`ifdef HEX_DIGITS_EN
      4'd10:   glyph = 7'b000_1000;
      4'd11:   glyph = 7'b110_0000;
      4'd12:   glyph = 7'b011_0001;
      4'd13:   glyph = 7'b100_0010;
      4'd14:   glyph = 7'b011_0000;
      4'd15:   glyph = 7'b011_1000;
`else
      default: begin
        glyph         = SEG_DARK;
        glyph_invalid = 1'b1;
      end
`endif
    endcase
  end

  // Overrides change only the segments; the invalid flag always tracks B.
  always_comb begin
    seg_d     = glyph;
    invalid_d = glyph_invalid;
    if (lamp_test) begin
      seg_d = SEG_LIT;
    end else if (blank) begin
      seg_d = SEG_DARK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= SEG_DARK;
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      invalid_q <= invalid_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign invalid               = invalid_q;

endmodule

// File: tb/tb_bcd_7segment_ca.sv
// Scoreboard bench for bcd_7segment_ca: directed vectors push hand-computed expectations,
// a monitor pops one entry per clock and compares it with the registered outputs.
module tb_bcd_7segment_ca;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] B;
  logic       lamp_test;
  logic       blank;
  logic       a, b, c, d, e, f, g;
  logic       invalid;

  typedef struct {
    int         id;
    logic [6:0] seg;
    logic       inv;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_id  = 0;

  bcd_7segment_ca dut (
    .clk       (clk),
    .rst       (rst),
    .B         (B),
    .lamp_test (lamp_test),
    .blank     (blank),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input int id, input logic [6:0] act_seg, input logic act_inv,
                       input logic [6:0] exp_seg, input logic exp_inv);
    n_tests++;
    if (act_seg !== exp_seg || act_inv !== exp_inv) begin
      n_fail++;
      $display("FAIL vec%0d: got seg=%b inv=%b, expected seg=%b inv=%b",
               id, act_seg, act_inv, exp_seg, exp_inv);
    end
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires one queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check(x.id, {a, b, c, d, e, f, g}, invalid, x.seg, x.inv);
    end
  end

  // Drive one vector between edges and record what the next edge must produce.
  task automatic vec(input logic r, input logic [3:0] code, input logic lt, input logic bl,
                     input logic [6:0] exp_seg, input logic exp_inv);
    exp_t x;
    @(negedge clk);
    rst       = r;
    B         = code;
    lamp_test = lt;
    blank     = bl;
    x.id  = vec_id;
    x.seg = exp_seg;
    x.inv = exp_inv;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Hand-written expectations for codes 10-15 in either build.
  function automatic logic [7:0] hi_exp(input logic [3:0] code);
`ifdef HEX_DIGITS_EN
    case (code)
      4'd10:   return {7'b000_1000, 1'b0};
      4'd11:   return {7'b110_0000, 1'b0};
      4'd12:   return {7'b011_0001, 1'b0};
      4'd13:   return {7'b100_0010, 1'b0};
      4'd14:   return {7'b011_0000, 1'b0};
      default: return {7'b011_1000, 1'b0};
    endcase
`else
    return {7'b111_1111, 1'b1};
`endif
  endfunction

`ifdef HEX_DIGITS_EN
  localparam logic HI_INV = 1'b0;
`else
  localparam logic HI_INV = 1'b1;
`endif

  initial begin
    logic [7:0] he;
    rst = 1'b1; B = 4'd8; lamp_test = 1'b0; blank = 1'b0;

    // Reset with B=8 for two cycles, then release with B=0.
    vec(1, 4'd8, 0, 0, 7'b111_1111, 0);
    vec(1, 4'd8, 0, 0, 7'b111_1111, 0);
    vec(0, 4'd0, 0, 0, 7'b000_0001, 0);

    // Count sweep 1..9.
    vec(0, 4'd1, 0, 0, 7'b100_1111, 0);
    vec(0, 4'd2, 0, 0, 7'b001_0010, 0);
    vec(0, 4'd3, 0, 0, 7'b000_0110, 0);
    vec(0, 4'd4, 0, 0, 7'b100_1100, 0);
    vec(0, 4'd5, 0, 0, 7'b010_0100, 0);
    vec(0, 4'd6, 0, 0, 7'b010_0000, 0);
    vec(0, 4'd7, 0, 0, 7'b000_1111, 0);
    vec(0, 4'd8, 0, 0, 7'b000_0000, 0);
    vec(0, 4'd9, 0, 0, 7'b000_0100, 0);

    // Codes 10-15, then back to a valid digit.
    for (int k = 10; k <= 15; k++) begin
      he = hi_exp(4'(k));
      vec(0, 4'(k), 0, 0, he[7:1], he[0]);
    end
    vec(0, 4'd3, 0, 0, 7'b000_0110, 0);

    // Overrides.
    vec(0, 4'd1, 1, 0, 7'b000_0000, 0);
    vec(0, 4'd1, 1, 1, 7'b000_0000, 0);
    vec(0, 4'd1, 0, 1, 7'b111_1111, 0);
    vec(0, 4'd1, 0, 0, 7'b100_1111, 0);
    vec(0, 4'd1, 0, 0, 7'b100_1111, 0);
    // invalid is still computed from B under lamp-test and blank.
    vec(0, 4'd12, 1, 0, 7'b000_0000, HI_INV);
    vec(0, 4'd14, 0, 1, 7'b111_1111, HI_INV);

    // Mid-stream reset beats lamp_test and blank, then release.
    vec(0, 4'd5, 0, 0, 7'b010_0100, 0);
    vec(1, 4'd5, 1, 0, 7'b111_1111, 0);
    vec(1, 4'd15, 0, 1, 7'b111_1111, 0);
    vec(0, 4'd7, 0, 0, 7'b000_1111, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
